// File: rtl/pd_dbglog_pkg.sv
// Shared types and header layout for the PD debug event logger.
package pd_dbglog_pkg;

    localparam int RECORD_W = 32;

    localparam int HDR_WRAP_BIT = 31;
    localparam int HDR_PTR_LSB  = 20;
    localparam int HDR_FILL_LSB = 16;
    localparam int HDR_DROP_LSB = 0;

    localparam logic [3:0] HDR_ADDR = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        HDR   = 2'd2
    } dbglog_state_t;

    function automatic logic [RECORD_W-1:0] make_header(
        input logic        wrapped,
        input logic [3:0]  ptr,
        input logic [3:0]  fill,
        input logic [15:0] drops
    );
        logic [RECORD_W-1:0] h;
        h                       = '0;
        h[HDR_WRAP_BIT]         = wrapped;
        h[HDR_PTR_LSB +: 4]     = ptr;
        h[HDR_FILL_LSB +: 4]    = fill;
        h[HDR_DROP_LSB +: 16]   = drops;
        return h;
    endfunction

endpackage

// File: rtl/pd_dbglog_fifo.sv
// Small synchronous record FIFO with a synchronous flush; read data is the
// current head, valid whenever the FIFO is not empty.
module pd_dbglog_fifo
    import pd_dbglog_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [RECORD_W-1:0]     wr_data,
    output logic [RECORD_W-1:0]     rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [RECORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/pd_debug_logger.sv
// Timestamps debug events and writes them as a circular log plus header word
// into the debug RAM port 2. Define PD_DBGLOG_DROPCNT_EN to report drop count.
module pd_debug_logger
    import pd_dbglog_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TS_W       = 16,
    parameter int LOG_WORDS  = 15
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                evt_valid,
    input  logic [15:0]         evt_code,
    input  logic                freeze,
    input  logic                clear,
    output logic [3:0]          address2,
    output logic [RECORD_W-1:0] writedata2,
    output logic [3:0]          byteenable2,
    output logic                chipselect2,
    output logic                write2,
    output logic                busy,
    output logic                drop_pulse
);

    localparam int         CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] LAST_SLOT = 4'(LOG_WORDS - 1);
    localparam logic [3:0] LOG_ADDR  = 4'(LOG_WORDS);
    localparam logic [3:0] FILL_MAX  = 4'(LOG_WORDS);

    dbglog_state_t       state, state_next;
    logic [TS_W-1:0]     ts;
    logic [3:0]          wr_ptr, wr_ptr_next;
    logic [3:0]          fill, fill_next;
    logic                wrapped, wrapped_next;
    logic [15:0]         drop_cnt_next;

    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]       fifo_count;
    logic [RECORD_W-1:0] fifo_rd_data;
    logic                drop;

    logic                write_d;
    logic [3:0]          addr_d;
    logic [RECORD_W-1:0] data_d;

    // Admission is judged on the count at cycle start, so a pop in the same
    // cycle never makes room for an event.
    assign fifo_push = evt_valid && !clear && (fifo_count < CW'(FIFO_DEPTH));
    assign drop      = evt_valid && !clear && fifo_full;
    assign fifo_pop  = (state == IDLE) && !freeze && !fifo_empty && !clear;

    pd_dbglog_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .flush   (clear),
        .wr_data ({16'(ts), evt_code}),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            ts      <= '0;
            wr_ptr  <= '0;
            fill    <= '0;
            wrapped <= 1'b0;
        end else begin
            state   <= state_next;
            ts      <= ts + TS_W'(1);
            wr_ptr  <= wr_ptr_next;
            fill    <= fill_next;
            wrapped <= wrapped_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    state_next = fifo_pop ? ENTRY : IDLE;
            ENTRY:   state_next = HDR;
            HDR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clear) begin
            state_next = HDR;
        end
    end

    // Ring bookkeeping advances as the ENTRY write retires, so the header
    // that follows already reflects it.
    always_comb begin
        wr_ptr_next  = wr_ptr;
        fill_next    = fill;
        wrapped_next = wrapped;
        if (clear) begin
            wr_ptr_next  = '0;
            fill_next    = '0;
            wrapped_next = 1'b0;
        end else if (state == ENTRY) begin
            if (wr_ptr == LAST_SLOT) begin
                wr_ptr_next  = '0;
                wrapped_next = 1'b1;
            end else begin
                wr_ptr_next = wr_ptr + 4'd1;
            end
            if (fill != FILL_MAX) begin
                fill_next = fill + 4'd1;
            end
        end
    end

`ifdef PD_DBGLOG_DROPCNT_EN
    logic [15:0] drop_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
        end else begin
            drop_cnt <= drop_cnt_next;
        end
    end

    always_comb begin
        drop_cnt_next = drop_cnt;
        if (clear) begin
            drop_cnt_next = '0;
        end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt_next = drop_cnt + 16'd1;
        end
    end
`else
    assign drop_cnt_next = '0;
`endif

    always_comb begin
        write_d = 1'b0;
        addr_d  = '0;
        data_d  = '0;
        unique case (state_next)
            ENTRY: begin
                write_d = 1'b1;
                addr_d  = wr_ptr_next;
                data_d  = fifo_rd_data;
            end
            HDR: begin
                write_d = 1'b1;
                addr_d  = LOG_ADDR;
                data_d  = make_header(wrapped_next, wr_ptr_next, fill_next, drop_cnt_next);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            write2      <= 1'b0;
            chipselect2 <= 1'b0;
            byteenable2 <= '0;
            address2    <= '0;
            writedata2  <= '0;
            drop_pulse  <= 1'b0;
        end else begin
            write2      <= write_d;
            chipselect2 <= write_d;
            byteenable2 <= {4{write_d}};
            address2    <= addr_d;
            writedata2  <= data_d;
            drop_pulse  <= drop;
        end
    end

    assign busy = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_pd_debug_logger.sv
// Directed bench for pd_debug_logger; mirrors RAM port-2 writes into a local array.
module tb_pd_debug_logger;

    logic        clk;
    logic        reset_n;
    logic        evt_valid;
    logic [15:0] evt_code;
    logic        freeze;
    logic        clear;
    logic [3:0]  address2;
    logic [31:0] writedata2;
    logic [3:0]  byteenable2;
    logic        chipselect2;
    logic        write2;
    logic        busy;
    logic        drop_pulse;

    int          n_pass  = 0;
    int          n_total = 0;
    int          cyc     = 0;
    int          wr_cnt  = 0;
    int          drop_seen = 0;
    logic [31:0] ram [16];
    logic [31:0] exp_rec [16];
    int          w0, d0;

    pd_debug_logger dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .evt_valid   (evt_valid),
        .evt_code    (evt_code),
        .freeze      (freeze),
        .clear       (clear),
        .address2    (address2),
        .writedata2  (writedata2),
        .byteenable2 (byteenable2),
        .chipselect2 (chipselect2),
        .write2      (write2),
        .busy        (busy),
        .drop_pulse  (drop_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    task automatic apply_stimulus(input logic v, input logic [15:0] code, input logic frz, input logic clr);
        evt_valid = v;
        evt_code  = code;
        freeze    = frz;
        clear     = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // RAM mirror plus per-cycle strobe consistency
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            check_output("cs_eq_wr", {31'b0, chipselect2}, {31'b0, write2});
            check_output("be_vs_wr", {28'b0, byteenable2}, write2 ? 32'hF : 32'h0);
        end
        if (write2 === 1'b1) begin
            ram[address2] = writedata2;
            wr_cnt++;
        end
        if (drop_pulse === 1'b1) begin
            drop_seen++;
        end
    end

    initial begin
        reset_n = 1'b0;
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0);
        repeat (3) tick();
        check_output("rst_write2", {31'b0, write2}, 32'h0);
        check_output("rst_busy", {31'b0, busy}, 32'h0);
        reset_n = 1'b1;
        cyc = 0;
        check_output("rst_addr", {28'b0, address2}, 32'h0);
        check_output("rst_data", writedata2, 32'h0);
        check_output("rst_drop", {31'b0, drop_pulse}, 32'h0);

        // Test 1: single event at ts 0x0010
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b1);
        tick();
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0);
        check_output("t1_clr_wr", {31'b0, write2}, 32'h1);
        check_output("t1_clr_addr", {28'b0, address2}, 32'hF);
        check_output("t1_clr_data", writedata2, 32'h0);
        while (cyc < 16) tick();
        apply_stimulus(1'b1, 16'h00A5, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0);
        check_output("t1_n1_wr", {31'b0, write2}, 32'h0);
        check_output("t1_n1_busy", {31'b0, busy}, 32'h1);
        tick();
        check_output("t1_ent_wr", {31'b0, write2}, 32'h1);
        check_output("t1_ent_addr", {28'b0, address2}, 32'h0);
        check_output("t1_ent_data", writedata2, 32'h001000A5);
        tick();
        check_output("t1_hdr_addr", {28'b0, address2}, 32'hF);
        check_output("t1_hdr_data", writedata2, 32'h00110000);
        tick();
        check_output("t1_idle_wr", {31'b0, write2}, 32'h0);
        check_output("t1_idle_busy", {31'b0, busy}, 32'h0);

        // Test 2: 16 events wrap the ring
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
            exp_rec[i] = {cyc[15:0], 16'h0100 + 16'(i)};
            tick();
            apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0);
            repeat (3) tick();
        end
        repeat (6) tick();
        check_output("t2_slot0", ram[0], exp_rec[15]);
        check_output("t2_slot1", ram[1], exp_rec[1]);
        check_output("t2_slot14", ram[14], exp_rec[14]);
        check_output("t2_hdr", ram[15], 32'h801F0000);
        check_output("t2_busy", {31'b0, busy}, 32'h0);

        // Test 3: freeze with six back-to-back events
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b1);
        tick();
        apply_stimulus(1'b0, 16'h0, 1'b1, 1'b0);
        tick();
        w0 = wr_cnt;
        d0 = drop_seen;
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b1, 16'h0300 + 16'(i), 1'b1, 1'b0);
            if (i < 4) exp_rec[i] = {cyc[15:0], 16'h0300 + 16'(i)};
            tick();
        end
        apply_stimulus(1'b0, 16'h0, 1'b1, 1'b0);
        repeat (4) tick();
        check_output("t3_frz_writes", 32'(wr_cnt - w0), 32'd0);
        check_output("t3_drops", 32'(drop_seen - d0), 32'd2);
        check_output("t3_frz_busy", {31'b0, busy}, 32'h1);
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0);
        repeat (14) tick();
        check_output("t3_writes", 32'(wr_cnt - w0), 32'd8);
        check_output("t3_slot0", ram[0], exp_rec[0]);
        check_output("t3_slot3", ram[3], exp_rec[3]);
`ifdef PD_DBGLOG_DROPCNT_EN
        check_output("t3_hdr", ram[15], 32'h00440002);
`else
        check_output("t3_hdr", ram[15], 32'h00440000);
`endif

        // Test 4: clear during an ENTRY write with events pending
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b1);
        tick();
        apply_stimulus(1'b1, 16'h0401, 1'b0, 1'b0);
        exp_rec[0] = {cyc[15:0], 16'h0401};
        tick();
        apply_stimulus(1'b1, 16'h0402, 1'b0, 1'b0);
        tick();
        check_output("t4_ent_wr", {31'b0, write2}, 32'h1);
        check_output("t4_ent_addr", {28'b0, address2}, 32'h0);
        check_output("t4_ent_data", writedata2, exp_rec[0]);
        apply_stimulus(1'b1, 16'h0403, 1'b0, 1'b1);
        tick();
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0);
        check_output("t4_hdr_addr", {28'b0, address2}, 32'hF);
        check_output("t4_hdr_data", writedata2, 32'h0);
        tick();
        check_output("t4_busy", {31'b0, busy}, 32'h0);
        w0 = wr_cnt;
        repeat (6) tick();
        check_output("t4_no_writes", 32'(wr_cnt - w0), 32'd0);

        // Test 5: reset during the header write
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b1);
        tick();
        apply_stimulus(1'b1, 16'h0501, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0);
        tick();
        tick();
        check_output("t5_hdr_wr", {31'b0, write2}, 32'h1);
        check_output("t5_hdr_addr", {28'b0, address2}, 32'hF);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("t5_async_wr", {31'b0, write2}, 32'h0);
        tick();
        tick();
        reset_n = 1'b1;
        cyc = 0;
        w0 = wr_cnt;
        repeat (8) tick();
        check_output("t5_quiet", 32'(wr_cnt - w0), 32'd0);
        check_output("t5_busy", {31'b0, busy}, 32'h0);
        apply_stimulus(1'b1, 16'h0555, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0);
        tick();
        check_output("t5_ent_addr", {28'b0, address2}, 32'h0);
        check_output("t5_ent_data", writedata2, 32'h00080555);
        tick();
        check_output("t5_hdr_data", writedata2, 32'h00110000);

`ifdef PD_DBGLOG_DROPCNT_EN
        // Test 6: drop counter saturation
        tick();
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b1);
        tick();
        d0 = drop_seen;
        apply_stimulus(1'b1, 16'h0600, 1'b1, 1'b0);
        repeat (70004) tick();
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0);
        repeat (14) tick();
        check_output("t6_drops", 32'(drop_seen - d0), 32'd70000);
        check_output("t6_hdr", ram[15], 32'h0044FFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
